// File: rtl/edge_dilate_pkg.sv
// edge_dilate_pkg
//   Shared definitions for the binary 3x3 morphology stages.
//   MODE_DILATE / MODE_ERODE : operator select (OR / AND of the 3x3 window)
//   PIX_ON                   : output level for a set pixel
//   morph_state_t            : sequencing states shared by the stages
//   morph_reduce()           : window reduction for a given operator
package edge_dilate_pkg;

    localparam int MODE_DILATE = 0;
    localparam int MODE_ERODE  = 1;
    localparam int PIX_ON      = 255;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } morph_state_t;

    // Border neighbours are substituted with the identity element of the
    // reduction beforehand, so a plain AND/OR is enough here.
    function automatic logic morph_reduce(input logic [8:0] win, input int mode);
        return (mode == MODE_ERODE) ? (&win) : (|win);
    endfunction

endpackage

// File: rtl/edge_dilate_line.sv
// bin_line_delay
//   1-bit raster delay line of depth 2*IW+3 with a 3x3 window extractor.
//   Ports:
//     clk    : clock
//     rst    : synchronous active-high reset, clears every tap
//     clear  : synchronous clear (frame abort), same effect as rst
//     shift  : advance the line by one pixel
//     din    : newest binarised pixel
//     win    : 3x3 window, win[3*i+j] = tap i*IW+j
//              i = 0 row below centre, 1 centre row, 2 row above
//              j = 0 column right of centre, 1 centre column, 2 left
module bin_line_delay
    import edge_dilate_pkg::*;
#(
    parameter int IW = 640
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       shift,
    input  logic       din,
    output logic [8:0] win
);

    localparam int DEPTH = 2 * IW + 3;

    logic [DEPTH-1:0] sr;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            sr <= '0;
        end else if (shift) begin
            sr <= {sr[DEPTH-2:0], din};
        end
    end

    always_comb begin
        win = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                win[3*i+j] = sr[i*IW+j];
            end
        end
    end

endmodule

// File: rtl/edge_dilate.sv
// edge_dilate
//   Binary 3x3 dilation (MODE=0) or erosion (MODE=1) of a raster edge map.
//   One output pixel per input pixel, same raster order; the last IW+1
//   outputs are produced by internal flush steps after the final input.
//   Ports:
//     clk        : clock, rising edge
//     rst        : synchronous active-high reset
//     din_valid  : input pixel qualifier (gaps allowed)
//     din        : edge pixel, nonzero = 1
//     vsync      : frame sync; rising edge aborts and restarts
//     dout       : PIX_ON or 0
//     dout_valid : output pixel qualifier
//     vsync_out  : vsync delayed by one clock
//     busy       : frame in progress (first accept .. last flush step)
//     err        : sticky, din_valid seen while flushing
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | no frame in progress; next din_valid starts a frame
//   RUN   | accepting pixels; emits once the window centre is valid
//   FLUSH | inputs complete; one pad shift per clock for IW+1 clocks
module edge_dilate
    import edge_dilate_pkg::*;
#(
    parameter int DW   = 14,
    parameter int IH   = 512,
    parameter int IW   = 640,
    parameter int MODE = MODE_DILATE
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          din_valid,
    input  logic [DW-1:0] din,
    input  logic          vsync,
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    output logic          vsync_out,
    output logic          busy,
    output logic          err
);

    localparam int NPIX = IH * IW;
    localparam int CW   = $clog2(NPIX + 1);
    localparam int RW   = (IH > 1) ? $clog2(IH) : 1;
    localparam int XW   = (IW > 1) ? $clog2(IW) : 1;
    localparam int FW   = $clog2(IW + 1);

    localparam logic [CW-1:0] IN_LAST    = CW'(NPIX - 1);
    localparam logic [CW-1:0] OUT_START  = CW'(IW + 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(IH - 1);
    localparam logic [XW-1:0] COL_LAST   = XW'(IW - 1);
    localparam logic [FW-1:0] FLUSH_LOAD = FW'(IW);
    // Identity element of the reduction: out-of-frame neighbours never
    // influence the result.
    localparam logic          PAD        = (MODE == MODE_ERODE);

    morph_state_t state, state_nxt;

    logic          vsync_rise;
    logic          accept;
    logic          flush_step;
    logic          emit_pend;
    logic [CW-1:0] in_cnt;
    logic [RW-1:0] out_row;
    logic [XW-1:0] out_col;
    logic [FW-1:0] flush_cnt;
    logic [8:0]    win;
    logic [8:0]    win_eff;
    logic [2:0]    row_ok;
    logic [2:0]    col_ok;
    logic          res;

    assign vsync_rise = vsync && !vsync_out;

    bin_line_delay #(
        .IW (IW)
    ) u_line (
        .clk   (clk),
        .rst   (rst),
        .clear (vsync_rise),
        .shift (accept || flush_step),
        .din   (din != '0),
        .win   (win)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (vsync_rise) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (din_valid) state_nxt = RUN;
                RUN:     if (din_valid && in_cnt == IN_LAST) state_nxt = FLUSH;
                FLUSH:   if (flush_cnt == '0) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        accept     = 1'b0;
        flush_step = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                accept = din_valid && !vsync_rise;
            end
            RUN: begin
                accept = din_valid && !vsync_rise;
                busy   = 1'b1;
            end
            FLUSH: begin
                flush_step = !vsync_rise;
                busy       = 1'b1;
            end
            default: ;
        endcase
    end

    // Window masking uses the coordinates of the centre pixel, which is
    // always the next pixel to be emitted.
    always_comb begin
        row_ok  = 3'b111;
        col_ok  = 3'b111;
        win_eff = '0;
        if (out_row == ROW_LAST) row_ok[0] = 1'b0;
        if (out_row == '0)       row_ok[2] = 1'b0;
        if (out_col == COL_LAST) col_ok[0] = 1'b0;
        if (out_col == '0)       col_ok[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                win_eff[3*i+j] = (row_ok[i] && col_ok[j]) ? win[3*i+j] : PAD;
            end
        end
        res = morph_reduce(win_eff, MODE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_cnt     <= '0;
            out_row    <= '0;
            out_col    <= '0;
            flush_cnt  <= '0;
            emit_pend  <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
            err        <= 1'b0;
            vsync_out  <= 1'b0;
        end else begin
            vsync_out  <= vsync;
            dout_valid <= 1'b0;
            if (vsync_rise) begin
                in_cnt    <= '0;
                out_row   <= '0;
                out_col   <= '0;
                flush_cnt <= '0;
                emit_pend <= 1'b0;
                err       <= 1'b0;
            end else begin
                if (state == FLUSH && din_valid) begin
                    err <= 1'b1;
                end
                // The window is evaluated one clock after the shift that
                // completed it, so the result is registered from a stable line.
                emit_pend <= (accept && in_cnt >= OUT_START) || flush_step;
                if (accept) begin
                    in_cnt <= in_cnt + 1'b1;
                    if (in_cnt == IN_LAST) begin
                        flush_cnt <= FLUSH_LOAD;
                    end
                end
                if (flush_step) begin
                    if (flush_cnt != '0) begin
                        flush_cnt <= flush_cnt - 1'b1;
                    end else begin
                        in_cnt <= '0;
                    end
                end
                if (emit_pend) begin
                    dout       <= res ? DW'(PIX_ON) : '0;
                    dout_valid <= 1'b1;
                    if (out_col == COL_LAST) begin
                        out_col <= '0;
                        out_row <= (out_row == ROW_LAST) ? '0 : out_row + 1'b1;
                    end else begin
                        out_col <= out_col + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_edge_dilate.sv
// tb_edge_dilate
//   Directed bench for edge_dilate at IW=8, IH=4. A dilate and an erode
//   instance share the same stimulus. Frames are 32-bit maps, bit k =
//   raster pixel k (row*8+col); expected output maps are hand-computed.
//   Erode expectations carry a care mask so that only pixels whose value
//   does not depend on the border pad are compared.
module tb_edge_dilate;

    localparam int DW   = 14;
    localparam int IH   = 4;
    localparam int IW   = 8;
    localparam int NPIX = IH * IW;

    logic          clk = 1'b0;
    logic          rst;
    logic          din_valid;
    logic [DW-1:0] din;
    logic          vsync;
    logic [DW-1:0] dout_d, dout_e;
    logic          dout_valid_d, dout_valid_e;
    logic          vsync_out_d, vsync_out_e;
    logic          busy_d, busy_e;
    logic          err_d, err_e;

    always #5 clk = ~clk;

    edge_dilate #(.DW(DW), .IH(IH), .IW(IW), .MODE(0)) dut_d (
        .clk        (clk),
        .rst        (rst),
        .din_valid  (din_valid),
        .din        (din),
        .vsync      (vsync),
        .dout       (dout_d),
        .dout_valid (dout_valid_d),
        .vsync_out  (vsync_out_d),
        .busy       (busy_d),
        .err        (err_d)
    );

    edge_dilate #(.DW(DW), .IH(IH), .IW(IW), .MODE(1)) dut_e (
        .clk        (clk),
        .rst        (rst),
        .din_valid  (din_valid),
        .din        (din),
        .vsync      (vsync),
        .dout       (dout_e),
        .dout_valid (dout_valid_e),
        .vsync_out  (vsync_out_e),
        .busy       (busy_e),
        .err        (err_e)
    );

    int          n_assert = 0;
    int          n_fail   = 0;
    int          cnt_d    = 0;
    int          cnt_e    = 0;
    int          bad_d    = 0;
    int          bad_e    = 0;
    logic [31:0] map_d    = '0;
    logic [31:0] map_e    = '0;
    bit          seen_out = 1'b0;
    time         t_in0, t_last, t_out0;

    always @(negedge clk) begin
        if (dout_valid_d) begin
            if (cnt_d < NPIX) map_d[cnt_d[4:0]] = (dout_d != '0);
            if (dout_d != '0 && dout_d != 14'd255) bad_d++;
            if (!seen_out) begin
                seen_out = 1'b1;
                t_out0   = $time;
            end
            cnt_d++;
        end
        if (dout_valid_e) begin
            if (cnt_e < NPIX) map_e[cnt_e[4:0]] = (dout_e != '0);
            if (dout_e != '0 && dout_e != 14'd255) bad_e++;
            cnt_e++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        cnt_d    = 0;
        cnt_e    = 0;
        bad_d    = 0;
        bad_e    = 0;
        map_d    = '0;
        map_e    = '0;
        seen_out = 1'b0;
    endtask

    task automatic vsync_pulse();
        @(negedge clk);
        vsync = 1'b1;
        @(negedge clk);
        vsync = 1'b0;
    endtask

    // Returns on the negedge just after the last pixel's accepting edge.
    task automatic send_frame(input logic [31:0] img, input bit gaps, input int npix);
        int g;
        for (int k = 0; k < npix; k++) begin
            @(negedge clk);
            if (gaps) begin
                g = $urandom_range(0, 2);
                repeat (g) begin
                    din_valid = 1'b0;
                    din       = '0;
                    @(negedge clk);
                end
            end
            din_valid = 1'b1;
            din       = img[k] ? DW'(k * 37 + 1) : '0;
            @(posedge clk);
            if (k == 0) t_in0 = $time;
            t_last = $time;
        end
        @(negedge clk);
        din_valid = 1'b0;
        din       = '0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((busy_d || busy_e) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_idle_timeout"}, (n < 200), 1);
        repeat (3) @(negedge clk);
        #1;
    endtask

    task automatic check_frame(input string tag, input logic [31:0] exp_d,
                               input logic [31:0] exp_e, input logic [31:0] care_e);
        check({tag, "_cnt_d"},  cnt_d, NPIX);
        check({tag, "_cnt_e"},  cnt_e, NPIX);
        check({tag, "_map_d"},  map_d, exp_d);
        check({tag, "_map_e"},  map_e & care_e, exp_e);
        check({tag, "_levels"}, bad_d + bad_e, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst       = 1'b1;
        din_valid = 1'b0;
        din       = '0;
        vsync     = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_dout",       dout_d, 0);
        check("rst_dout_valid", {dout_valid_d, dout_valid_e}, 0);
        check("rst_busy",       {busy_d, busy_e}, 0);
        check("rst_err",        {err_d, err_e}, 0);
        check("rst_vsync_out",  vsync_out_d, 0);
        rst = 1'b0;

        // vsync_out is vsync delayed one clock
        @(negedge clk);
        vsync = 1'b1;
        #1 check("vsync_out_pre", vsync_out_d, 0);
        @(negedge clk);
        check("vsync_out_dly", vsync_out_d, 1);
        vsync = 1'b0;

        // all-zero frame, latency and busy fall
        clear_mon();
        send_frame(32'h0000_0000, 1'b0, NPIX);
        n = 0;
        while (busy_d && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("busy_fall_clks", n, 9);
        wait_idle("zero");
        check("first_out_lat", 32'((t_out0 - t_in0 - 5) / 10), 10);
        check_frame("zero", 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF);

        // single pixel at (1,3)
        vsync_pulse();
        clear_mon();
        send_frame(32'h0000_0800, 1'b0, NPIX);
        wait_idle("pt13");
        check_frame("pt13", 32'h001C_1C1C, 32'h0000_0000, 32'hFFFF_FFFF);

        // single pixel at (0,7), back-to-back frame without vsync
        clear_mon();
        send_frame(32'h0000_0080, 1'b0, NPIX);
        wait_idle("pt07");
        check_frame("pt07", 32'h0000_C0C0, 32'h0000_0000, 32'hFFFF_FFFF);

        // all-255 frame
        vsync_pulse();
        clear_mon();
        send_frame(32'hFFFF_FFFF, 1'b0, NPIX);
        wait_idle("ones");
        check_frame("ones", 32'hFFFF_FFFF, 32'h007E_7E00, 32'h007E_7E00);

        // all-255 with a hole at (1,3)
        vsync_pulse();
        clear_mon();
        send_frame(32'hFFFF_F7FF, 1'b0, NPIX);
        wait_idle("hole13");
        check_frame("hole13", 32'hFFFF_FFFF, 32'h0062_6200, 32'h007E_7E1C);

        // input gaps
        vsync_pulse();
        clear_mon();
        send_frame(32'h0000_0800, 1'b1, NPIX);
        wait_idle("gap13");
        check_frame("gap13", 32'h001C_1C1C, 32'h0000_0000, 32'hFFFF_FFFF);

        vsync_pulse();
        clear_mon();
        send_frame(32'h0100_0000, 1'b1, NPIX);
        wait_idle("gap30");
        check_frame("gap30", 32'h0303_0000, 32'h0000_0000, 32'hFFFF_FFFF);

        // vsync abort during flush after 4 flush outputs (23 run + 4)
        vsync_pulse();
        clear_mon();
        send_frame(32'h0000_0800, 1'b0, NPIX);
        n = 0;
        while (cnt_d < 27 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("abort_reach_27", cnt_d, 27);
        vsync = 1'b1;
        @(negedge clk);
        #1;
        check("abort_busy", {busy_d, busy_e}, 0);
        repeat (20) @(negedge clk);
        #1;
        check("abort_cnt_d", cnt_d, 27);
        check("abort_cnt_e", cnt_e, 27);
        vsync = 1'b0;
        clear_mon();
        send_frame(32'h0000_0080, 1'b0, NPIX);
        wait_idle("post_abort");
        check_frame("post_abort", 32'h0000_C0C0, 32'h0000_0000, 32'hFFFF_FFFF);

        // din_valid while flushing sets sticky err; vsync clears it
        vsync_pulse();
        clear_mon();
        send_frame(32'h0100_0000, 1'b0, NPIX);
        check("err_pre", err_d, 0);
        @(negedge clk);
        din_valid = 1'b1;
        din       = 14'd255;
        @(negedge clk);
        din_valid = 1'b0;
        din       = '0;
        #1 check("err_set", {err_d, err_e}, 2'b11);
        wait_idle("err_frame");
        check_frame("err_frame", 32'h0303_0000, 32'h0000_0000, 32'hFFFF_FFFF);
        check("err_held", err_d, 1);
        @(negedge clk);
        vsync = 1'b1;
        @(negedge clk);
        #1 check("err_clr", {err_d, err_e}, 0);
        vsync = 1'b0;

        // reset mid-frame: no partial output afterwards
        vsync_pulse();
        clear_mon();
        send_frame(32'hFFFF_FFFF, 1'b0, 13);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("rst_mid_state", {busy_d, dout_valid_d, busy_e, dout_valid_e}, 0);
        clear_mon();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        #1 check("rst_mid_no_out", cnt_d + cnt_e, 0);
        clear_mon();
        send_frame(32'h0000_0800, 1'b0, NPIX);
        wait_idle("after_rst");
        check_frame("after_rst", 32'h001C_1C1C, 32'h0000_0000, 32'hFFFF_FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
